dma_scheduler: RTL and testbench
================================

# dma_scheduler

Four-channel DMA start/priority scheduler for the GBA core. Sits between the DMA MMIO registers (DMAxCNT_H fields) and the shared DMA transfer engine: it turns register writes, video blanking edges and sound-FIFO requests into per-channel pending requests, grants the single engine to the highest-priority pending channel (channel 0 highest), and stalls the CPU while any transfer is in flight. Preemption happens only at unit (halfword/word) boundaries.

## Interface
- NUM_CH, 4, number of channels; fixed at 4, priority by index, lowest index wins
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  4  DMAxCNT_H bit 15 per channel
- start_timing  in  8  DMAxCNT_H[13:12] per channel; ch i at [2i+1:2i]; 00 immediate, 01 vblank, 10 hblank, 11 special
- repeat_en  in  4  DMAxCNT_H bit 9 per channel
- vblank, hblank  in  1  level blanking flags from the LCD timing block
- fifo_req  in  2  sound FIFO A/B refill requests; bit 0 serves ch1, bit 1 serves ch2
- unit_done  in  1  engine finished one unit for the granted channel (1-cycle pulse)
- last_unit  in  1  qualifies unit_done: the unit just finished was the final one of the count
- grant  out  4  one-hot granted channel; all-zero when idle
- load  out  1  1-cycle pulse telling the engine to load/restore the granted channel's context
- busy  out  1  scheduler not IDLE
- cpu_pause  out  1  equal to busy; stalls the CPU
- done  out  4  1-cycle completion pulse per channel (IRQ source)
- clear_enable  out  4  1-cycle pulse to clear DMAxCNT_H bit 15

## Operation
- Edge detect: registered copies of enable, vblank, hblank, fifo_req; triggers are 0->1 transitions only.
- Trigger per channel (only while enable=1): timing 00 -> rising edge of enable; 01 -> vblank rise; 10 -> hblank rise; 11 -> ch1/ch2 fifo_req rise, ch0 never (prohibited), ch3 never (video capture unimplemented).
- pending[i] set by trigger; already-pending trigger is ignored (no counting). Cleared when ch i completes, or when enable[i] is 0.
- FSM states: IDLE, SETUP, RUN, DONE.
  - IDLE: if any pending, latch winner = lowest-index pending, go SETUP.
  - SETUP (1 cycle): grant=winner, load=1, go RUN.
  - RUN: grant held. On unit_done & last_unit -> DONE. On unit_done & ~last_unit and a pending channel with lower index than current -> SETUP with that channel (preempted channel stays pending, engine keeps its context). Otherwise stay.
  - DONE (1 cycle): done[cur]=1; pending[cur] cleared; clear_enable[cur]=1 if repeat_en[cur]=0 or timing=00; go IDLE.
- Enable drop of the granted channel: abort to IDLE next cycle, grant cleared, no done, no clear_enable.
- Trigger of the granted channel during RUN: ignored (pending already set).
- Simultaneous vblank and hblank rise: both sets of channels triggered; arbitration resolves order.
- unit_done while not in RUN: ignored.

## Timing
- Reset: grant=0, load=0, busy=0, cpu_pause=0, done=0, clear_enable=0, pending=0, state IDLE, edge registers=0 (a level already high at reset release produces an edge).
- Trigger edge sampled at clock k -> pending visible after k+1 -> SETUP (grant, load) after k+2 -> RUN after k+3.
- After last unit_done at clock m: DONE after m+1 (done, clear_enable pulses), IDLE after m+2; next pending channel enters SETUP after m+3.
- Preemption switch: unit_done at m -> SETUP for new channel after m+1.
- All outputs registered; busy covers SETUP, RUN, DONE.

## Test plan
- Ch3 timing 00, enable 0->1; engine pulses unit_done 3 times, last on 3rd -> grant=4'b1000 two cycles after enable edge, load one cycle, done[3] and clear_enable[3] one cycle after 3rd unit_done, busy low after.
- Ch0 and ch2 both timing 01, one vblank rise -> ch0 granted first, done[0], IDLE, then ch2 granted; ch2 repeat_en=1 -> no clear_enable[2].
- Ch3 running 8 units, ch1 hblank trigger mid-run -> switch to ch1 after next unit_done (not before), ch1 completes, ch3 re-loaded and finishes remaining units.
- Ch1 timing 11, fifo_req[0] pulses twice while pending -> one transfer only; ch0 timing 11 with fifo pulses -> never granted.
- Ch2 running, enable[2] deasserted -> grant=0 next cycle, no done[2], busy low.
- Assert rst_n low mid-RUN -> all outputs 0 immediately; after release no spurious grant unless an input edge occurs.

Source files
------------

// File: rtl/dma_scheduler.sv
// Four-channel DMA start/priority scheduler: turns MMIO enables, blanking edges and
// sound-FIFO requests into pending requests and grants the shared engine by priority.
module dma_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] enable,
    input  logic [7:0] start_timing,
    input  logic [3:0] repeat_en,
    input  logic       vblank,
    input  logic       hblank,
    input  logic [1:0] fifo_req,
    input  logic       unit_done,
    input  logic       last_unit,
    output logic [3:0] grant,
    output logic       load,
    output logic       busy,
    output logic       cpu_pause,
    output logic [3:0] done,
    output logic [3:0] clear_enable
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     cur_q, cur_d;
    logic [NUM_CH-1:0]   enable_q;
    logic                vblank_q, hblank_q;
    logic [1:0]          fifo_q;
    logic [NUM_CH-1:0]   trig_q, trig_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic                load_q, load_d;
    logic                busy_q, busy_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [NUM_CH-1:0]   clear_enable_q, clear_enable_d;

    logic [NUM_CH-1:0]   en_rise;
    logic                vb_rise, hb_rise;
    logic [NUM_CH-1:0]   fifo_map;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   preempt;
    logic [NUM_CH-1:0]   pend_clr;
    logic [1:0]          cur_timing;

    function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
        lowest_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = CH_W'(i);
        end
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        onehot = NUM_CH'(1) << idx;
    endfunction

    // Per-channel start triggers, registered one stage before they reach pending.
    always_comb begin
        en_rise  = enable & ~enable_q;
        vb_rise  = vblank & ~vblank_q;
        hb_rise  = hblank & ~hblank_q;
        // Special timing: FIFO A feeds ch1, FIFO B feeds ch2; ch0 and ch3 never fire.
        fifo_map = {1'b0, fifo_req[1] & ~fifo_q[1], fifo_req[0] & ~fifo_q[0], 1'b0};
        trig_d   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            case (start_timing[2*i +: 2])
                2'b00:   trig_d[i] = en_rise[i];
                2'b01:   trig_d[i] = vb_rise;
                2'b10:   trig_d[i] = hb_rise;
                default: trig_d[i] = fifo_map[i];
            endcase
        end
        trig_d = trig_d & enable;
    end

    assign eligible   = pending_q & enable;
    assign preempt    = eligible & (onehot(cur_q) - NUM_CH'(1));
    assign cur_timing = start_timing[{cur_q, 1'b0} +: 2];

    // Scheduler next state and registered outputs.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        grant_d        = grant_q;
        load_d         = 1'b0;
        busy_d         = busy_q;
        done_d         = '0;
        clear_enable_d = '0;
        pend_clr       = '0;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (|eligible) begin
                    cur_d   = lowest_idx(eligible);
                    state_d = S_SETUP;
                    grant_d = onehot(lowest_idx(eligible));
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SETUP: begin
                if (!enable[cur_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable[cur_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (unit_done && last_unit) begin
                    state_d = S_DONE;
                    grant_d = '0;
                    done_d  = onehot(cur_q);
                    if (!repeat_en[cur_q] || cur_timing == 2'b00) begin
                        clear_enable_d = onehot(cur_q);
                    end
                end else if (unit_done && |preempt) begin
                    // Switch only at a unit boundary; the preempted channel stays pending.
                    cur_d   = lowest_idx(preempt);
                    state_d = S_SETUP;
                    grant_d = onehot(lowest_idx(preempt));
                    load_d  = 1'b1;
                end
            end
            S_DONE: begin
                pend_clr = onehot(cur_q);
                state_d  = S_IDLE;
                grant_d  = '0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
        pending_d = ((pending_q & ~pend_clr) | trig_q) & enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cur_q          <= '0;
            enable_q       <= '0;
            vblank_q       <= 1'b0;
            hblank_q       <= 1'b0;
            fifo_q         <= '0;
            trig_q         <= '0;
            pending_q      <= '0;
            grant_q        <= '0;
            load_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= '0;
            clear_enable_q <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            enable_q       <= enable;
            vblank_q       <= vblank;
            hblank_q       <= hblank;
            fifo_q         <= fifo_req;
            trig_q         <= trig_d;
            pending_q      <= pending_d;
            grant_q        <= grant_d;
            load_q         <= load_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            clear_enable_q <= clear_enable_d;
        end
    end

    assign grant        = grant_q;
    assign load         = load_q;
    assign busy         = busy_q;
    assign cpu_pause    = busy_q;
    assign done         = done_q;
    assign clear_enable = clear_enable_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// Scoreboard bench for dma_scheduler: expected load/done events are queued as stimulus
// is driven and matched against the DUT's load and done/clear_enable pulses.
module tb_dma_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] enable;
    logic [7:0] start_timing;
    logic [3:0] repeat_en;
    logic       vblank, hblank;
    logic [1:0] fifo_req;
    logic       unit_done, last_unit;
    logic [3:0] grant;
    logic       load, busy, cpu_pause;
    logic [3:0] done, clear_enable;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    dma_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .start_timing (start_timing),
        .repeat_en    (repeat_en),
        .vblank       (vblank),
        .hblank       (hblank),
        .fifo_req     (fifo_req),
        .unit_done    (unit_done),
        .last_unit    (last_unit),
        .grant        (grant),
        .load         (load),
        .busy         (busy),
        .cpu_pause    (cpu_pause),
        .done         (done),
        .clear_enable (clear_enable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int ch);
        return 4'(1 << ch);
    endfunction

    task automatic exp_load(input int ch);
        exp_q.push_back({4'h1, oh(ch), 4'h0});
    endtask

    task automatic exp_done(input int ch, input bit ce);
        exp_q.push_back({4'h2, oh(ch), ce ? oh(ch) : 4'h0});
    endtask

    // Scoreboard side: every load pulse and every done/clear_enable pulse must be expected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load) begin
                if (exp_q.size() == 0) check("sb_unexpected_load", {20'h0, 4'h1, grant, 4'h0}, 32'h0);
                else check("sb_load", {20'h0, 4'h1, grant, 4'h0}, {20'h0, exp_q.pop_front()});
            end
            if (done != 4'h0 || clear_enable != 4'h0) begin
                if (exp_q.size() == 0) check("sb_unexpected_done", {20'h0, 4'h2, done, clear_enable}, 32'h0);
                else check("sb_done", {20'h0, 4'h2, done, clear_enable}, {20'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string tag);
        int k = 0;
        while (grant !== exp && k < 40) begin
            tick();
            k++;
        end
        check(tag, 32'(grant), 32'(exp));
    endtask

    task automatic unit_pulse(input bit last);
        unit_done = 1'b1;
        last_unit = last;
        tick();
        unit_done = 1'b0;
        last_unit = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_busy;
        rst_n        = 1'b0;
        enable       = '0;
        start_timing = '0;
        repeat_en    = '0;
        vblank       = 1'b0;
        hblank       = 1'b0;
        fifo_req     = '0;
        unit_done    = 1'b0;
        last_unit    = 1'b0;
        tick(3);
        check("reset_outputs", {18'h0, grant, load, busy, cpu_pause, done, clear_enable}, 32'h0);
        rst_n = 1'b1;
        tick(3);
        check("idle_after_reset", {27'h0, grant, busy}, 32'h0);

        // Ch3 immediate start, three units.
        exp_load(3);
        exp_done(3, 1'b1);
        start_timing[7:6] = 2'b00;
        enable[3] = 1'b1;
        tick();
        check("t1_no_grant_k", 32'(grant), 32'h0);
        tick();
        check("t1_no_grant_k1", 32'(grant), 32'h0);
        tick();
        check("t1_setup", {26'h0, grant, load, cpu_pause}, {26'h0, 4'b1000, 1'b1, 1'b1});
        tick();
        check("t1_run", {27'h0, grant, load}, {27'h0, 4'b1000, 1'b0});
        unit_pulse(1'b0);
        tick();
        unit_pulse(1'b0);
        tick();
        unit_pulse(1'b1);
        check("t1_done", {23'h0, done, clear_enable, busy}, {23'h0, 4'b1000, 4'b1000, 1'b1});
        tick();
        check("t1_idle", {25'h0, busy, cpu_pause, grant, done}, 32'h0);
        enable[3] = 1'b0;
        tick(2);

        // Ch0 and ch2 on one vblank rise; ch2 repeats so keeps its enable.
        start_timing[1:0] = 2'b01;
        start_timing[5:4] = 2'b01;
        repeat_en[2] = 1'b1;
        enable[0] = 1'b1;
        enable[2] = 1'b1;
        tick(2);
        check("t2_no_enable_trigger", 32'(busy), 32'h0);
        exp_load(0);
        exp_done(0, 1'b1);
        exp_load(2);
        exp_done(2, 1'b0);
        vblank = 1'b1;
        wait_grant(4'b0001, "t2_grant_ch0");
        tick();
        unit_pulse(1'b0);
        unit_pulse(1'b1);
        check("t2_done_ch0", {24'h0, done, clear_enable}, {24'h0, 4'b0001, 4'b0001});
        tick();
        check("t2_idle_between", 32'(busy), 32'h0);
        wait_grant(4'b0100, "t2_grant_ch2");
        tick();
        unit_pulse(1'b1);
        check("t2_done_ch2", {24'h0, done, clear_enable}, {24'h0, 4'b0100, 4'b0000});
        tick();
        vblank = 1'b0;
        enable = '0;
        repeat_en = '0;
        tick(2);

        // Ch3 eight units preempted by ch1 on hblank at the next unit boundary.
        start_timing[7:6] = 2'b00;
        start_timing[3:2] = 2'b10;
        exp_load(3);
        enable[3] = 1'b1;
        wait_grant(4'b1000, "t3_grant_ch3");
        tick();
        unit_pulse(1'b0);
        unit_pulse(1'b0);
        exp_load(1);
        exp_done(1, 1'b1);
        exp_load(3);
        exp_done(3, 1'b1);
        enable[1] = 1'b1;
        hblank = 1'b1;
        tick(5);
        check("t3_no_early_switch", 32'(grant), 32'(4'b1000));
        unit_pulse(1'b0);
        check("t3_preempt_setup", {27'h0, grant, load}, {27'h0, 4'b0010, 1'b1});
        tick();
        unit_pulse(1'b1);
        check("t3_done_ch1", 32'(done), 32'(4'b0010));
        wait_grant(4'b1000, "t3_resume_ch3");
        tick();
        for (int i = 0; i < 4; i++) unit_pulse(1'b0);
        unit_pulse(1'b1);
        check("t3_done_ch3", 32'(done), 32'(4'b1000));
        tick();
        check("t3_idle", 32'(busy), 32'h0);
        enable = '0;
        hblank = 1'b0;
        tick(2);

        // Ch1 special timing: repeated fifo pulses while pending give one transfer.
        start_timing[3:2] = 2'b11;
        repeat_en[1] = 1'b1;
        exp_load(1);
        exp_done(1, 1'b0);
        enable[1] = 1'b1;
        tick();
        fifo_req[0] = 1'b1;
        tick();
        fifo_req[0] = 1'b0;
        tick();
        fifo_req[0] = 1'b1;
        tick();
        fifo_req[0] = 1'b0;
        wait_grant(4'b0010, "t4_grant_ch1");
        tick();
        unit_pulse(1'b0);
        unit_pulse(1'b1);
        check("t4_done_ch1", {24'h0, done, clear_enable}, {24'h0, 4'b0010, 4'b0000});
        tick(10);
        check("t4_single_transfer", {27'h0, grant, busy}, 32'h0);
        enable = '0;
        repeat_en = '0;
        tick(2);

        // Ch0 special timing is prohibited and must never be granted.
        start_timing[1:0] = 2'b11;
        enable[0] = 1'b1;
        any_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fifo_req = 2'b11;
            tick();
            any_busy |= busy;
            fifo_req = 2'b00;
            tick();
            any_busy |= busy;
        end
        tick(3);
        any_busy |= busy;
        check("t4_ch0_never", 32'(any_busy), 32'h0);
        enable = '0;
        tick(2);

        // Enable drop of the granted channel aborts without done.
        start_timing[5:4] = 2'b00;
        exp_load(2);
        enable[2] = 1'b1;
        wait_grant(4'b0100, "t5_grant_ch2");
        tick();
        unit_pulse(1'b0);
        enable[2] = 1'b0;
        tick();
        check("t5_abort", {22'h0, grant, busy, cpu_pause, done}, 32'h0);
        tick(5);
        check("t5_stay_idle", {27'h0, grant, busy}, 32'h0);

        // Asynchronous reset in the middle of a run.
        start_timing[7:6] = 2'b00;
        exp_load(3);
        enable[3] = 1'b1;
        wait_grant(4'b1000, "t6_grant_ch3");
        tick();
        unit_pulse(1'b0);
        rst_n = 1'b0;
        enable = '0;
        #1;
        check("t6_async_reset", {18'h0, grant, load, busy, cpu_pause, done, clear_enable}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("t6_no_spurious", {27'h0, grant, busy}, 32'h0);

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
